// File: rtl/othello_move_ctrl_if.sv
// Bundles the move-entry handshake and the board RAM port used by othello_move_ctrl.
// The master side is the environment (requester plus RAM); the slave side is the controller.
interface othello_move_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              move_req;
  logic [5:0]        move_sq;
  logic              pass_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_wdata;
  logic              mem_wren;
  logic [1:0]        mem_rdata;
  logic              busy;
  logic              move_ack;
  logic              move_nack;
  logic              player;
  logic [4:0]        flip_count;

  modport master (
    output move_req, move_sq, pass_req, mem_rdata,
    input  mem_addr, mem_wdata, mem_wren, busy, move_ack, move_nack, player, flip_count
  );

  modport slave (
    input  move_req, move_sq, pass_req, mem_rdata,
    output mem_addr, mem_wdata, mem_wren, busy, move_ack, move_nack, player, flip_count
  );
endinterface

// File: rtl/othello_move_ctrl.sv
// Sequences one Othello move on a 10x10 walled board RAM: empty check, 8-direction
// scan, flip writes, disc placement, then ack/nack. Owns the side-to-move register.
module othello_move_ctrl #(
  parameter int ADDR_W = 7,
  parameter int BASE   = 11,
  parameter int STRIDE = 10
) (
  input logic               clock,
  input logic               reset,
  othello_move_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_ORG   = 4'd1,
    S_CHK_ORG  = 4'd2,
    S_DIR_INIT = 4'd3,
    S_SC_RD    = 4'd4,
    S_SC_EVAL  = 4'd5,
    S_FLIP     = 4'd6,
    S_NEXT_DIR = 4'd7,
    S_PLACE    = 4'd8,
    S_ACK      = 4'd9,
    S_NACK     = 4'd10
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_C  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ZERO_C = ADDR_W'(1'b0);

  function automatic logic [ADDR_W-1:0] calc_org(input logic [5:0] sq);
    calc_org = ADDR_W'(BASE) + ADDR_W'(sq[5:3]) * ADDR_W'(STRIDE) + ADDR_W'(sq[2:0]);
  endfunction

  // Two's-complement step for each of the 8 scan directions, scanned in this order.
  function automatic logic [ADDR_W-1:0] dir_offset(input logic [2:0] d);
    case (d)
      3'd0:    dir_offset = ZERO_C - ADDR_W'(STRIDE) - ONE_C;
      3'd1:    dir_offset = ZERO_C - ADDR_W'(STRIDE);
      3'd2:    dir_offset = ZERO_C - ADDR_W'(STRIDE) + ONE_C;
      3'd3:    dir_offset = ZERO_C - ONE_C;
      3'd4:    dir_offset = ONE_C;
      3'd5:    dir_offset = ADDR_W'(STRIDE) - ONE_C;
      3'd6:    dir_offset = ADDR_W'(STRIDE);
      3'd7:    dir_offset = ADDR_W'(STRIDE) + ONE_C;
      default: dir_offset = ZERO_C;
    endcase
  endfunction

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] org_r, org_next_s;
  logic [ADDR_W-1:0] pos_r, pos_next_s;
  logic [2:0]        dir_r, dir_next_s;
  logic [2:0]        k_r, k_next_s;
  logic [4:0]        total_r, total_next_s;
  logic              player_r, player_next_s;
  logic [4:0]        flip_count_r, flip_count_next_s;

  logic [ADDR_W-1:0] mem_addr_r, mem_addr_next_s;
  logic [1:0]        mem_wdata_r, mem_wdata_next_s;
  logic              mem_wren_r, mem_wren_next_s;
  logic              busy_r, busy_next_s;
  logic              move_ack_r, move_ack_next_s;
  logic              move_nack_r, move_nack_next_s;

  logic [ADDR_W-1:0] off_s;
  logic [1:0]        own_s;
  logic [1:0]        opp_s;

  assign off_s = dir_offset(dir_r);
  assign own_s = player_r ? 2'b10 : 2'b01;
  assign opp_s = player_r ? 2'b01 : 2'b10;

  // Next-state and datapath update for the move sequencer.
  always_comb begin
    state_next_s      = state_r;
    org_next_s        = org_r;
    pos_next_s        = pos_r;
    dir_next_s        = dir_r;
    k_next_s          = k_r;
    total_next_s      = total_r;
    player_next_s     = player_r;
    flip_count_next_s = flip_count_r;
    case (state_r)
      S_IDLE: begin
        if (bus.move_req) begin
          org_next_s   = calc_org(bus.move_sq);
          state_next_s = S_RD_ORG;
        end else if (bus.pass_req) begin
          player_next_s = ~player_r;
        end else begin
          player_next_s = player_r;
        end
      end
      S_RD_ORG: state_next_s = S_CHK_ORG;
      S_CHK_ORG: begin
        if (bus.mem_rdata != 2'b00) begin
          state_next_s = S_NACK;
        end else begin
          total_next_s = 5'd0;
          dir_next_s   = 3'd0;
          state_next_s = S_DIR_INIT;
        end
      end
      S_DIR_INIT: begin
        pos_next_s   = org_r + off_s;
        k_next_s     = 3'd0;
        state_next_s = S_SC_RD;
      end
      S_SC_RD: state_next_s = S_SC_EVAL;
      S_SC_EVAL: begin
        if (bus.mem_rdata == opp_s) begin
          k_next_s     = k_r + 3'd1;
          pos_next_s   = pos_r + off_s;
          state_next_s = S_SC_RD;
        end else if ((bus.mem_rdata == own_s) && (k_r != 3'd0)) begin
          pos_next_s   = pos_r - off_s;
          state_next_s = S_FLIP;
        end else begin
          state_next_s = S_NEXT_DIR;
        end
      end
      // Flips walk back toward the origin; the cell adjacent to it is the last one.
      S_FLIP: begin
        total_next_s = total_r + 5'd1;
        pos_next_s   = pos_r - off_s;
        if (pos_r == (org_r + off_s)) begin
          state_next_s = S_NEXT_DIR;
        end else begin
          state_next_s = S_FLIP;
        end
      end
      S_NEXT_DIR: begin
        if (dir_r == 3'd7) begin
          if (total_r != 5'd0) begin
            state_next_s = S_PLACE;
          end else begin
            state_next_s = S_NACK;
          end
        end else begin
          dir_next_s   = dir_r + 3'd1;
          state_next_s = S_DIR_INIT;
        end
      end
      S_PLACE: state_next_s = S_ACK;
      S_ACK: begin
        flip_count_next_s = total_r;
        player_next_s     = ~player_r;
        state_next_s      = S_IDLE;
      end
      S_NACK:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output values for the state being entered, so the registered outputs line up with it.
  always_comb begin
    mem_addr_next_s  = ZERO_C;
    mem_wdata_next_s = 2'b00;
    mem_wren_next_s  = 1'b0;
    move_ack_next_s  = 1'b0;
    move_nack_next_s = 1'b0;
    busy_next_s      = (state_next_s != S_IDLE);
    case (state_next_s)
      S_RD_ORG: mem_addr_next_s = org_next_s;
      S_SC_RD:  mem_addr_next_s = pos_next_s;
      S_FLIP: begin
        mem_addr_next_s  = pos_next_s;
        mem_wdata_next_s = own_s;
        mem_wren_next_s  = 1'b1;
      end
      S_PLACE: begin
        mem_addr_next_s  = org_r;
        mem_wdata_next_s = own_s;
        mem_wren_next_s  = 1'b1;
      end
      S_ACK:   move_ack_next_s  = 1'b1;
      S_NACK:  move_nack_next_s = 1'b1;
      default: mem_addr_next_s  = ZERO_C;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      org_r        <= ZERO_C;
      pos_r        <= ZERO_C;
      dir_r        <= 3'd0;
      k_r          <= 3'd0;
      total_r      <= 5'd0;
      player_r     <= 1'b0;
      flip_count_r <= 5'd0;
      mem_addr_r   <= ZERO_C;
      mem_wdata_r  <= 2'b00;
      mem_wren_r   <= 1'b0;
      busy_r       <= 1'b0;
      move_ack_r   <= 1'b0;
      move_nack_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      org_r        <= org_next_s;
      pos_r        <= pos_next_s;
      dir_r        <= dir_next_s;
      k_r          <= k_next_s;
      total_r      <= total_next_s;
      player_r     <= player_next_s;
      flip_count_r <= flip_count_next_s;
      mem_addr_r   <= mem_addr_next_s;
      mem_wdata_r  <= mem_wdata_next_s;
      mem_wren_r   <= mem_wren_next_s;
      busy_r       <= busy_next_s;
      move_ack_r   <= move_ack_next_s;
      move_nack_r  <= move_nack_next_s;
    end
  end

  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_wren   = mem_wren_r;
  assign bus.busy       = busy_r;
  assign bus.move_ack   = move_ack_r;
  assign bus.move_nack  = move_nack_r;
  assign bus.player     = player_r;
  assign bus.flip_count = flip_count_r;

endmodule

// File: tb/tb_othello_move_ctrl.sv
// Directed bench for othello_move_ctrl: behavioural board RAM with 1-cycle read latency,
// write logger, and one task per scenario with hand-computed expectations.
module tb_othello_move_ctrl;

  logic clock;
  logic reset;

  othello_move_ctrl_if #(.ADDR_W(7)) bus();

  othello_move_ctrl #(.ADDR_W(7), .BASE(11), .STRIDE(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors;
  int miscompares;
  int cycle;

  logic [1:0] ram [0:127];
  logic [1:0] init_board [0:99];
  logic       ram_load;

  int         wr_addr_q [$];
  logic [1:0] wr_data_q [$];
  int         wr_cyc_q  [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Board RAM: bulk load from init_board, otherwise 1-cycle read and write port.
  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < 100; i++) ram[i] <= init_board[i];
    end else begin
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  always @(negedge clock) begin
    if (bus.mem_wren === 1'b1) begin
      wr_addr_q.push_back(int'(bus.mem_addr));
      wr_data_q.push_back(bus.mem_wdata);
      wr_cyc_q.push_back(cycle);
    end
  end

  task automatic set_walls();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        init_board[r*10+c] = (r == 0 || r == 9 || c == 0 || c == 9) ? 2'b11 : 2'b00;
  endtask

  task automatic load_board();
    @(negedge clock); ram_load = 1'b1;
    @(negedge clock); ram_load = 1'b0;
  endtask

  task automatic load_start();
    set_walls();
    init_board[44] = 2'b10; init_board[45] = 2'b01;
    init_board[54] = 2'b01; init_board[55] = 2'b10;
    load_board();
  endtask

  task automatic apply_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); reset = 1'b0;
  endtask

  task automatic run_move(input logic [5:0] sq, output int lat, output logic got_ack, output logic got_nack);
    @(negedge clock);
    bus.move_req = 1'b1; bus.move_sq = sq;
    lat = 0; got_ack = 1'b0; got_nack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1; lat++;
      if (bus.move_ack === 1'b1 || bus.move_nack === 1'b1) begin
        got_ack = bus.move_ack; got_nack = bus.move_nack;
        break;
      end
    end
    bus.move_req = 1'b0;
    if (!got_ack && !got_nack) begin
      vectors++; miscompares++;
      $display("FAIL move_timeout sq=%0d: got no ack/nack, required one within 300 cycles", sq);
    end
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    vectors++; if (bus.mem_wren !== 1'b0) begin miscompares++; $display("FAIL rst_wren: got %b, required 0", bus.mem_wren); end
    vectors++; if (bus.mem_addr !== 7'd0) begin miscompares++; $display("FAIL rst_addr: got %0d, required 0", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 2'b00) begin miscompares++; $display("FAIL rst_wdata: got %b, required 00", bus.mem_wdata); end
    vectors++; if ({bus.move_ack, bus.move_nack} !== 2'b00) begin miscompares++; $display("FAIL rst_ack_nack: got %b, required 00", {bus.move_ack, bus.move_nack}); end
    vectors++; if (bus.player !== 1'b0) begin miscompares++; $display("FAIL rst_player: got %b, required 0", bus.player); end
    vectors++; if (bus.flip_count !== 5'd0) begin miscompares++; $display("FAIL rst_flip_count: got %0d, required 0", bus.flip_count); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_basic_move();
    int lat; logic a, n; int wb;
    apply_reset(); load_start();
    wb = wr_addr_q.size();
    run_move(6'd19, lat, a, n);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL basic_ack: got %b, required 1", a); end
    vectors++; if (wr_addr_q.size() - wb !== 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d, required 2", wr_addr_q.size() - wb); end
    if (wr_addr_q.size() - wb >= 2) begin
      vectors++; if (wr_addr_q[wb] !== 44 || wr_data_q[wb] !== 2'b01) begin miscompares++; $display("FAIL basic_flip: got addr %0d data %b, required 44 01", wr_addr_q[wb], wr_data_q[wb]); end
      vectors++; if (wr_addr_q[wb+1] !== 34 || wr_data_q[wb+1] !== 2'b01) begin miscompares++; $display("FAIL basic_place: got addr %0d data %b, required 34 01", wr_addr_q[wb+1], wr_data_q[wb+1]); end
    end
    @(posedge clock); #1;
    vectors++; if (bus.flip_count !== 5'd1) begin miscompares++; $display("FAIL basic_flip_count: got %0d, required 1", bus.flip_count); end
    vectors++; if (bus.player !== 1'b1) begin miscompares++; $display("FAIL basic_player: got %b, required 1", bus.player); end
    vectors++; if (bus.busy !== 1'b0 || bus.mem_addr !== 7'd0) begin miscompares++; $display("FAIL basic_idle: got busy %b addr %0d, required 0 0", bus.busy, bus.mem_addr); end
  endtask

  task automatic test_occupied();
    int lat; logic a, n; int wb;
    apply_reset(); load_start();
    wb = wr_addr_q.size();
    run_move(6'd27, lat, a, n);
    vectors++; if (n !== 1'b1 || a !== 1'b0) begin miscompares++; $display("FAIL occ_nack: got ack %b nack %b, required 0 1", a, n); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL occ_latency: got %0d, required 3", lat); end
    vectors++; if (wr_addr_q.size() - wb !== 0) begin miscompares++; $display("FAIL occ_nwrites: got %0d, required 0", wr_addr_q.size() - wb); end
    @(posedge clock); #1;
    vectors++; if (bus.player !== 1'b0) begin miscompares++; $display("FAIL occ_player: got %b, required 0", bus.player); end
  endtask

  task automatic test_no_bracket();
    int lat; logic a, n; int wb;
    apply_reset(); load_start();
    wb = wr_addr_q.size();
    run_move(6'd0, lat, a, n);
    vectors++; if (n !== 1'b1 || a !== 1'b0) begin miscompares++; $display("FAIL nobr_nack: got ack %b nack %b, required 0 1", a, n); end
    // 2 check cycles + 8 dirs x (init, read, eval, next) + nack entry
    vectors++; if (lat !== 35) begin miscompares++; $display("FAIL nobr_latency: got %0d, required 35", lat); end
    vectors++; if (wr_addr_q.size() - wb !== 0) begin miscompares++; $display("FAIL nobr_nwrites: got %0d, required 0", wr_addr_q.size() - wb); end
  endtask

  task automatic test_long_row();
    int lat; logic a, n; int wb; logic [5:0] seen;
    apply_reset();
    set_walls();
    init_board[21] = 2'b01;
    for (int i = 22; i <= 27; i++) init_board[i] = 2'b10;
    load_board();
    wb = wr_addr_q.size();
    run_move(6'd15, lat, a, n);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL row_ack: got %b, required 1", a); end
    vectors++; if (wr_addr_q.size() - wb !== 7) begin miscompares++; $display("FAIL row_nwrites: got %0d, required 7", wr_addr_q.size() - wb); end
    if (wr_addr_q.size() - wb >= 7) begin
      seen = 6'd0;
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wr_addr_q[wb+i] < 22 || wr_addr_q[wb+i] > 27 || wr_data_q[wb+i] !== 2'b01) begin
          miscompares++; $display("FAIL row_flip%0d: got addr %0d data %b, required 22..27 01", i, wr_addr_q[wb+i], wr_data_q[wb+i]);
        end else begin
          seen[wr_addr_q[wb+i]-22] = 1'b1;
        end
        if (i > 0) begin
          vectors++; if (wr_cyc_q[wb+i] !== wr_cyc_q[wb+i-1] + 1) begin miscompares++; $display("FAIL row_consecutive%0d: got cycle %0d, required %0d", i, wr_cyc_q[wb+i], wr_cyc_q[wb+i-1] + 1); end
        end
      end
      vectors++; if (seen !== 6'b111111) begin miscompares++; $display("FAIL row_distinct: got mask %b, required 111111", seen); end
      vectors++; if (wr_addr_q[wb+6] !== 28 || wr_data_q[wb+6] !== 2'b01) begin miscompares++; $display("FAIL row_place: got addr %0d data %b, required 28 01", wr_addr_q[wb+6], wr_data_q[wb+6]); end
    end
    @(posedge clock); #1;
    vectors++; if (bus.flip_count !== 5'd6) begin miscompares++; $display("FAIL row_flip_count: got %0d, required 6", bus.flip_count); end
    vectors++; if (bus.player !== 1'b1) begin miscompares++; $display("FAIL row_player: got %b, required 1", bus.player); end
  endtask

  task automatic test_pass();
    logic seen_nack; int wb;
    apply_reset(); load_start();
    @(negedge clock); bus.pass_req = 1'b1;
    @(negedge clock); bus.pass_req = 1'b0;
    vectors++; if (bus.player !== 1'b1) begin miscompares++; $display("FAIL pass_toggle: got %b, required 1", bus.player); end
    wb = wr_addr_q.size();
    @(negedge clock); bus.move_req = 1'b1; bus.pass_req = 1'b1; bus.move_sq = 6'd27;
    @(posedge clock); #1; bus.pass_req = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL pass_move_wins_busy: got %b, required 1", bus.busy); end
    bus.move_req = 1'b0; bus.pass_req = 1'b1;
    @(posedge clock); #1; bus.pass_req = 1'b0;
    seen_nack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.move_nack === 1'b1) begin seen_nack = 1'b1; break; end
      @(posedge clock); #1;
    end
    vectors++; if (seen_nack !== 1'b1) begin miscompares++; $display("FAIL pass_nack: got %b, required 1", seen_nack); end
    @(posedge clock); #1;
    vectors++; if (bus.player !== 1'b1) begin miscompares++; $display("FAIL pass_dropped: got %b, required 1", bus.player); end
    vectors++; if (wr_addr_q.size() - wb !== 0) begin miscompares++; $display("FAIL pass_nwrites: got %0d, required 0", wr_addr_q.size() - wb); end
  endtask

  task automatic test_reset_mid_flip();
    logic in_flip;
    set_walls();
    init_board[21] = 2'b10;
    for (int i = 22; i <= 27; i++) init_board[i] = 2'b01;
    load_board();
    @(negedge clock); bus.move_req = 1'b1; bus.move_sq = 6'd15;
    in_flip = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (bus.mem_wren === 1'b1) begin in_flip = 1'b1; break; end
    end
    bus.move_req = 1'b0;
    vectors++; if (in_flip !== 1'b1) begin miscompares++; $display("FAIL midrst_reach_flip: got %b, required 1", in_flip); end
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b0 || bus.mem_wren !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got busy %b wren %b, required 0 0", bus.busy, bus.mem_wren); end
    vectors++; if (bus.player !== 1'b0) begin miscompares++; $display("FAIL midrst_player: got %b, required 0", bus.player); end
    vectors++; if (bus.flip_count !== 5'd0) begin miscompares++; $display("FAIL midrst_flip_count: got %0d, required 0", bus.flip_count); end
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cycle = 0;
    reset = 1'b1; ram_load = 1'b0;
    bus.move_req = 1'b0; bus.move_sq = 6'd0; bus.pass_req = 1'b0;
    set_walls();
    test_reset();
    test_basic_move();
    test_occupied();
    test_no_bracket();
    test_long_row();
    test_reset_mid_flip();
    test_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
